// File: rtl/mdu_pkg.sv
// Shared md-op and MDU mod encodings plus default MDU latencies.
// Imported by both mdu_ctrl and the MDU so the two always agree.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8,
    OP_MADD  = 4'd9
  } md_op_e;

  typedef enum logic [2:0] {
    MOD_MUL_S = 3'b000,
    MOD_MUL_U = 3'b001,
    MOD_DIV_S = 3'b010,
    MOD_DIV_U = 3'b011,
    MOD_MT_HI = 3'b100,
    MOD_MT_LO = 3'b101,
    MOD_MADD  = 3'b110,
    MOD_IDLE  = 3'b111
  } mdu_mod_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } ctrl_state_e;

  localparam int unsigned MUL_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF = 10;
  localparam int unsigned CNT_W          = 4;

endpackage

// File: rtl/mdu_ctrl.sv
// EX-stage MDU controller: issues start/mod, muxes HI/LO for mf reads, stalls D
// while a mul/div is in flight and flags any disagreement between its counter and mdu_busy.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  d_md_op,
  input  logic [3:0]  e_md_op,
  input  logic        e_valid,
  input  logic        mdu_busy,
  input  logic [31:0] mdu_hi,
  input  logic [31:0] mdu_lo,
  output logic        mdu_start,
  output logic [2:0]  mdu_mod,
  output logic        stall_d,
  output logic [31:0] e_mf_data,
  output logic        e_mf_valid,
  output logic        err
);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_CYCLES);

  ctrl_state_e      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_chk, w_chk_nxt;
  logic             r_err, w_err_nxt;
  logic             w_is_mul, w_is_div, w_mismatch;

  // IDLE must be driven whenever nothing is issued: any other mod with start=0 is a move.
  always_comb begin
    mdu_start = 1'b0;
    mdu_mod   = MOD_IDLE;
    w_is_mul  = 1'b0;
    w_is_div  = 1'b0;
    if (e_valid) begin
      case (e_md_op)
        OP_MULT:  begin mdu_start = 1'b1; mdu_mod = MOD_MUL_S; w_is_mul = 1'b1; end
        OP_MULTU: begin mdu_start = 1'b1; mdu_mod = MOD_MUL_U; w_is_mul = 1'b1; end
        OP_DIV:   begin mdu_start = 1'b1; mdu_mod = MOD_DIV_S; w_is_div = 1'b1; end
        OP_DIVU:  begin mdu_start = 1'b1; mdu_mod = MOD_DIV_U; w_is_div = 1'b1; end
        OP_MADD:  begin mdu_start = 1'b1; mdu_mod = MOD_MADD;  end
        OP_MTHI:  mdu_mod = MOD_MT_HI;
        OP_MTLO:  mdu_mod = MOD_MT_LO;
        default:  mdu_mod = MOD_IDLE;
      endcase
    end
  end

  always_comb begin
    e_mf_data  = '0;
    e_mf_valid = 1'b0;
    if (e_md_op == OP_MFHI) begin
      e_mf_data  = mdu_hi;
      e_mf_valid = e_valid;
    end else if (e_md_op == OP_MFLO) begin
      e_mf_data  = mdu_lo;
      e_mf_valid = e_valid;
    end
  end

  // mdu_start term covers the issue cycle, before the MDU has raised busy.
  assign stall_d = (d_md_op != OP_NONE) && ((r_cnt != '0) || mdu_busy || mdu_start);

  assign w_mismatch = r_chk && (mdu_busy != (r_cnt != '0));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_chk_nxt   = r_chk;
    w_err_nxt   = r_err;
    case (r_state)
      ST_IDLE: begin
        if (w_is_mul && (MUL_CNT != '0)) begin
          w_cnt_nxt   = MUL_CNT;
          w_state_nxt = ST_BUSY;
        end else if (w_is_div && (DIV_CNT != '0)) begin
          w_cnt_nxt   = DIV_CNT;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Checking window runs through the first cycle with cnt back at 0, so a late busy drop is caught.
    if (w_is_mul || w_is_div) w_chk_nxt = 1'b1;
    else if (r_cnt == '0)     w_chk_nxt = 1'b0;
    if ((mdu_start && (r_cnt != '0)) || w_mismatch) w_err_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_chk   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_chk   <= w_chk_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign err = r_err;

endmodule
